l2_cacheline_adapter: RTL and testbench

Bridges the L2 cache's full-line data path to the narrow burst-oriented memory port. On a miss it collects a line fill from memory beat by beat and presents it as one `s_line`-bit word to the L2 data array. On a dirty eviction it takes one `s_line`-bit victim line and streams it out as ordered beats. It sits between the L2 cache controller/data array and the physical memory interface.

---
 rtl/l2_cacheline_adapter.sv | 161 ++++++++++++++++
 tb/tb_l2_cacheline_adapter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter
//   Bridges the L2 full-line data path to a narrow burst memory port.
//   Line fill: collects `beats` read beats from memory into line_o.
//   Writeback: streams a victim line out to memory as ordered beats.
//
// Optional feature macro: L2_ADAPTER_REQ_LATCH_EN
//   defined   : address_i and line_i are captured on acceptance, so the cache
//               may change them after the accept edge.
//   undefined : address_o is combinational from address_i and write beats are
//               sliced from line_i; the cache holds both until resp_o.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   read_i     line fill request from cache
//   write_i    line writeback request from cache
//   address_i  line address from cache
//   line_i     victim line for writeback
//   line_o     assembled fill line (valid while resp_o = 1)
//   resp_o     one-cycle completion pulse to cache
//   address_o  memory address, line offset bits cleared
//   read_o     memory read request
//   write_o    memory write request
//   burst_o    write beat to memory
//   burst_i    read beat from memory
//   resp_i     memory beat acknowledge, one beat per high cycle
//
// state | meaning
// IDLE  | waiting for a request; write has priority over read
// READ  | collecting fill beats into line_o
// WRITE | streaming victim beats on burst_o
// DONE  | resp_o high for one cycle, then back to IDLE
module l2_cacheline_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [31:0]         address_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  output logic                resp_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [s_burst-1:0]  burst_o,
  input  logic [s_burst-1:0]  burst_i,
  input  logic                resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int s_off = $clog2(s_line / 8);
  localparam int CW    = (beats > 1) ? $clog2(beats) : 1;
  // Clears the byte-offset-within-line bits of an address.
  localparam logic [31:0] OFF_MASK = ~((32'd1 << s_off) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_inc;
  logic              w_last;
  logic [31:0]       w_lo_cur;
  logic [31:0]       w_lo_nxt;
  logic [s_line-1:0] w_line;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (r_cnt == CW'(beats - 1));
  assign w_lo_cur  = s_burst * 32'(r_cnt);
  // Only used when not on the last beat, so it never leaves the line.
  assign w_lo_nxt  = s_burst * 32'(w_cnt_inc);

`ifdef L2_ADAPTER_REQ_LATCH_EN
  logic [31:0]       r_addr;
  logic [s_line-1:0] r_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_line <= '0;
    end else if (r_state == IDLE) begin
      if (write_i || read_i) r_addr <= address_i;
      if (write_i)           r_line <= line_i;
    end
  end

  assign w_line    = r_line;
  assign address_o = r_addr & OFF_MASK;
`else
  assign w_line    = line_i;
  assign address_o = address_i & OFF_MASK;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      line_o  <= '0;
      resp_o  <= 1'b0;
      read_o  <= 1'b0;
      write_o <= 1'b0;
      burst_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write_i) begin
            r_state <= WRITE;
            r_cnt   <= '0;
            write_o <= 1'b1;
            // First beat comes straight from line_i: the latched copy is
            // only written on this same edge.
            burst_o <= line_i[s_burst-1:0];
          end else if (read_i) begin
            r_state <= READ;
            r_cnt   <= '0;
            read_o  <= 1'b1;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[w_lo_cur +: s_burst] <= burst_i;
            if (w_last) begin
              r_state <= DONE;
              r_cnt   <= '0;
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (w_last) begin
              r_state <= DONE;
              r_cnt   <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_inc;
              burst_o <= w_line[w_lo_nxt +: s_burst];
            end
          end
        end
        DONE: begin
          resp_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          resp_o  <= 1'b0;
          read_o  <= 1'b0;
          write_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
module tb_l2_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  l2_cacheline_adapter #(.s_line(256), .s_burst(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;

  initial begin
    rst       = 1'b0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = 32'h0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    #2;
    check("rst_line_o",    line_o,    256'h0);
    check("rst_resp_o",    resp_o,    1'b0);
    check("rst_read_o",    read_o,    1'b0);
    check("rst_write_o",   write_o,   1'b0);
    check("rst_burst_o",   burst_o,   64'h0);
    check("rst_address_o", address_o, 32'h0);
    step();
    step();
    rst = 1'b1;
    step();

    // Fill with resp_i held high.
    read_i    = 1'b1;
    address_i = 32'h0000_1234;
    resp_i    = 1'b1;
    burst_i   = 64'h1111_1111_1111_1111;
    step();
    check("fill_read_o",    read_o,    1'b1);
    check("fill_write_o",   write_o,   1'b0);
    check("fill_address_o", address_o, 32'h0000_1220);
    step();
    burst_i = 64'h2222_2222_2222_2222;
    step();
    burst_i = 64'h3333_3333_3333_3333;
    step();
    check("fill_no_early_resp", resp_o, 1'b0);
    burst_i = 64'h4444_4444_4444_4444;
    step();
    check("fill_resp_o", resp_o, 1'b1);
    check("fill_read_o_done", read_o, 1'b0);
    check("fill_line_o", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    read_i = 1'b0;
    resp_i = 1'b0;
    step();
    check("fill_resp_one_cycle", resp_o, 1'b0);

    // Writeback with acks 1,0,1,0,...
    write_i   = 1'b1;
    address_i = 32'h0000_3000;
    line_i    = {BD, BC, BB, BA};
    step();
    check("wb_write_o",  write_o, 1'b1);
    check("wb_read_o",   read_o,  1'b0);
    check("wb_burst_0",  burst_o, BA);
    resp_i = 1'b1; step();
    check("wb_burst_1",  burst_o, BB);
    resp_i = 1'b0; step();
    check("wb_hold_1",   burst_o, BB);
    resp_i = 1'b1; step();
    check("wb_burst_2",  burst_o, BC);
    resp_i = 1'b0; step();
    check("wb_hold_2",   burst_o, BC);
    resp_i = 1'b1; step();
    check("wb_burst_3",  burst_o, BD);
    resp_i = 1'b0; step();
    check("wb_hold_3",   burst_o, BD);
    check("wb_write_stall", write_o, 1'b1);
    check("wb_no_early_resp", resp_o, 1'b0);
    resp_i = 1'b1; step();
    check("wb_resp_o",   resp_o,  1'b1);
    check("wb_write_o_done", write_o, 1'b0);
    write_i = 1'b0;
    resp_i  = 1'b0;
    step();
    check("wb_resp_one_cycle", resp_o, 1'b0);

    // Read and write together: write first, then read.
    read_i    = 1'b1;
    write_i   = 1'b1;
    address_i = 32'h0000_4000;
    line_i    = {4{64'h0F0F_0F0F_0F0F_0F0F}};
    resp_i    = 1'b1;
    burst_i   = 64'h5555_5555_5555_5555;
    step();
    check("both_write_o", write_o, 1'b1);
    check("both_read_o",  read_o,  1'b0);
    step(); step(); step(); step();
    check("both_resp_1", resp_o, 1'b1);
    write_i = 1'b0;
    step();
    check("both_idle_read_o", read_o, 1'b0);
    check("both_idle_resp_o", resp_o, 1'b0);
    step();
    check("both_read_started", read_o, 1'b1);
    check("both_write_low",    write_o, 1'b0);
    step();
    burst_i = 64'h6666_6666_6666_6666; step();
    burst_i = 64'h7777_7777_7777_7777; step();
    burst_i = 64'h8888_8888_8888_8888; step();
    check("both_resp_2", resp_o, 1'b1);
    check("both_line_o", line_o, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                  64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    read_i = 1'b0;
    step();

    // Reset after two read beats.
    read_i    = 1'b1;
    address_i = 32'h8000_0040;
    resp_i    = 1'b1;
    burst_i   = 64'h9999_9999_9999_9999;
    step();
    step();
    burst_i = 64'hABAB_ABAB_ABAB_ABAB;
    step();
    rst       = 1'b0;
    read_i    = 1'b0;
    resp_i    = 1'b0;
    address_i = 32'h0;
    #1;
    check("mid_rst_read_o",    read_o,    1'b0);
    check("mid_rst_line_o",    line_o,    256'h0);
    check("mid_rst_resp_o",    resp_o,    1'b0);
    check("mid_rst_burst_o",   burst_o,   64'h0);
    check("mid_rst_address_o", address_o, 32'h0);
    rst = 1'b1;
    step();
    check("post_rst_resp_o", resp_o, 1'b0);
    check("post_rst_read_o", read_o, 1'b0);
    read_i    = 1'b1;
    address_i = 32'h0000_0100;
    resp_i    = 1'b1;
    burst_i   = 64'h0101_0101_0101_0101;
    step();
    step();
    burst_i = 64'h0202_0202_0202_0202; step();
    burst_i = 64'h0303_0303_0303_0303; step();
    burst_i = 64'h0404_0404_0404_0404; step();
    check("post_rst_fill_resp", resp_o, 1'b1);
    check("post_rst_fill_line", line_o, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                         64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
    read_i = 1'b0;
    step();

    // resp_i in IDLE with no request is ignored.
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); step(); step();
    check("idle_ack_line_o",  line_o, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                       64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
    check("idle_ack_resp_o",  resp_o,  1'b0);
    check("idle_ack_read_o",  read_o,  1'b0);
    check("idle_ack_write_o", write_o, 1'b0);
    resp_i = 1'b0;

`ifdef L2_ADAPTER_REQ_LATCH_EN
    // Request inputs change right after a write is accepted.
    write_i   = 1'b1;
    address_i = 32'h0000_2004;
    line_i    = {BD, BC, BB, BA};
    step();
    address_i = 32'hFFFF_FFE0;
    line_i    = {4{64'h1234_5678_9ABC_DEF0}};
    #1;
    check("latch_address_o", address_o, 32'h0000_2000);
    check("latch_burst_0",   burst_o,   BA);
    resp_i = 1'b1; step();
    check("latch_burst_1",   burst_o,   BB);
    step();
    check("latch_burst_2",   burst_o,   BC);
    step();
    check("latch_burst_3",   burst_o,   BD);
    check("latch_address_hold", address_o, 32'h0000_2000);
    step();
    check("latch_resp_o",    resp_o,    1'b1);
    write_i = 1'b0;
    resp_i  = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
